// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: instruction ROM port, redirect request and the
// valid/ready instruction stream towards the decoder.
interface imem_fetch_ctrl_if #(
  parameter int AW = 8
);
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          redirect_valid;
  logic [63:0]   redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_data;
  logic [63:0]   instr_pc;
  logic          halted;

  modport master (
    output imem_addr,
    input  imem_q,
    input  redirect_valid,
    input  redirect_addr,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output redirect_valid,
    output redirect_addr,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    input  halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks a byte PC through a combinational ROM,
// buffers {instr, pc} in a small FIFO and stops fetching after HALT_WORD.
module imem_fetch_ctrl #(
  parameter int          AW        = 8,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_WORD  = 32'h8b1f03ff,
  parameter logic [31:0] HALT_WORD = 32'hb400001f
) (
  input logic             clk,
  input logic             reset,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state, state_nx;
  logic [63:0]   pc;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [63:0]   q_pc    [DEPTH];
  logic          valid, pop, push;

  always_comb begin
    valid    = (count != '0);
    pop      = 1'b0;
    push     = 1'b0;
    state_nx = state;
    // Redirect wins over everything in its cycle: no pop, no push.
    if (bus.redirect_valid) begin
      state_nx = RUN;
    end else begin
      pop  = valid && bus.instr_ready;
      push = (state == RUN) && ((count < FULL) || pop);
      if (push && (bus.imem_q == HALT_WORD))
        state_nx = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      pc     <= bus.redirect_addr & ~64'h3;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 64'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_q;
      q_pc[wr_ptr]    <= pc;
    end
  end

  assign bus.imem_addr   = pc[AW+1:2];
  assign bus.instr_valid = valid;
  assign bus.instr_data  = valid ? q_instr[rd_ptr] : NOP_WORD;
  assign bus.instr_pc    = valid ? q_pc[rd_ptr] : 64'd0;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: vector table for streaming, backpressure
// and redirect, plus hand sequences for halt, resume and mid-run reset.
module tb_imem_fetch_ctrl;

  localparam int          AW   = 8;
  localparam logic [31:0] NOP  = 32'h8b1f03ff;
  localparam logic [31:0] HALT = 32'hb400001f;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.AW(AW)) bus ();

  imem_fetch_ctrl #(
    .AW(AW), .DEPTH(2), .NOP_WORD(NOP), .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] rom [256];
  assign bus.imem_q = rom[bus.imem_addr];

  function automatic logic [31:0] romw(input int i);
    logic [7:0]  lo = 8'(i);
    logic [15:0] mix = 16'(i * 3 + 1);
    return (i == 20) ? HALT : {8'hA5, lo, mix};
  endfunction

  typedef struct {
    logic          rdy;
    logic          rv;
    logic [63:0]   ra;
    logic          e_valid;
    logic [63:0]   e_pc;
    logic [31:0]   e_data;
    logic [AW-1:0] e_addr;
    logic          e_halt;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [63:0] ra,
                              input logic ev, input logic [63:0] epc, input int eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.ra = ra;
    v.e_valid = ev;
    v.e_pc    = ev ? epc : 64'd0;
    v.e_data  = ev ? romw(int'(epc >> 2)) : NOP;
    v.e_addr  = AW'(eaddr);
    v.e_halt  = 1'b0;
    return v;
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [63:0] epc,
                         input logic [31:0] edata, input int eaddr, input logic eh);
    chk({tag, ".valid"},  64'(bus.instr_valid), 64'(ev));
    chk({tag, ".pc"},     bus.instr_pc, epc);
    chk({tag, ".data"},   64'(bus.instr_data), 64'(edata));
    chk({tag, ".addr"},   64'(bus.imem_addr), 64'(eaddr));
    chk({tag, ".halted"}, 64'(bus.halted), 64'(eh));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = romw(i);

    tbl[0]  = mk(1, 0, 64'd0,  1, 64'd0,  1);
    tbl[1]  = mk(1, 0, 64'd0,  1, 64'd4,  2);
    tbl[2]  = mk(1, 0, 64'd0,  1, 64'd8,  3);
    tbl[3]  = mk(1, 0, 64'd0,  1, 64'd12, 4);
    tbl[4]  = mk(0, 1, 64'd0,  0, 64'd0,  0);
    tbl[5]  = mk(0, 0, 64'd0,  1, 64'd0,  1);
    tbl[6]  = mk(0, 0, 64'd0,  1, 64'd0,  2);
    tbl[7]  = mk(0, 0, 64'd0,  1, 64'd0,  2);
    tbl[8]  = mk(0, 0, 64'd0,  1, 64'd0,  2);
    tbl[9]  = mk(0, 0, 64'd0,  1, 64'd0,  2);
    tbl[10] = mk(0, 0, 64'd0,  1, 64'd0,  2);
    tbl[11] = mk(1, 0, 64'd0,  1, 64'd4,  3);
    tbl[12] = mk(1, 0, 64'd0,  1, 64'd8,  4);
    tbl[13] = mk(1, 0, 64'd0,  1, 64'd12, 5);
    tbl[14] = mk(1, 1, 64'h2B, 0, 64'd0,  10);
    tbl[15] = mk(0, 0, 64'd0,  1, 64'h28, 11);

    reset = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    #3;
    chk_out("reset", 0, 64'd0, NOP, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.instr_ready    = tbl[i].rdy;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_addr  = tbl[i].ra;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_data,
              int'(tbl[i].e_addr), tbl[i].e_halt);
    end
    bus.redirect_valid = 1'b0;

    // Stream from 0x2C up to the HALT_WORD at word 20.
    bus.instr_ready = 1'b1;
    for (int k = 11; k <= 20; k++) begin
      step();
      chk_out($sformatf("run%0d", k), 1, 64'(k * 4), romw(k), k + 1, k == 20);
    end
    step();
    chk_out("drain", 0, 64'd0, NOP, 21, 1);
    step();
    chk_out("halt_idle", 0, 64'd0, NOP, 21, 1);

    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 64'd0;
    step();
    chk_out("resume_redir", 0, 64'd0, NOP, 0, 0);
    bus.redirect_valid = 1'b0;
    step();
    chk_out("resume_fetch", 1, 64'd0, romw(0), 1, 0);

    // Fill the queue, then drop reset between clock edges.
    bus.instr_ready = 1'b0;
    step();
    chk_out("prefill", 1, 64'd0, romw(0), 2, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 0, 64'd0, NOP, 0, 0);
    @(posedge clk);
    #1;
    chk_out("rst_held", 0, 64'd0, NOP, 0, 0);
    reset = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    chk_out("restart0", 1, 64'd0, romw(0), 1, 0);
    step();
    chk_out("restart1", 1, 64'd4, romw(1), 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter AW, default 8, meaning instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 2, meaning fetch-queue entries (power of two, >= 2).
REQ-003 Parameter NOP_WORD, default 32'h8b1f03ff, meaning value driven on instr_data when no entry is valid.
REQ-004 Parameter HALT_WORD, default 32'hb400001f, meaning the program-terminating instruction encoding.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 imem_addr  out  AW  word address to the combinational instruction ROM.
REQ-008 imem_q  in  32  ROM read data for imem_addr, valid in the same cycle.
REQ-009 redirect_valid  in  1  one-cycle request to restart fetch at redirect_addr.
REQ-010 redirect_addr  in  64  byte target address for a redirect.
REQ-011 instr_valid  out  1  head of the fetch queue is valid.
REQ-012 instr_ready  in  1  consumer accepts the head this cycle.
REQ-013 instr_data  out  32  instruction at the head of the queue.
REQ-014 instr_pc  out  64  byte address of instr_data.
REQ-015 halted  out  1  controller is in state HALT.

Function
REQ-016 The block SHALL hold a 64-bit byte PC, a DEPTH-entry FIFO of {instr, pc} and a two-state FSM: RUN and HALT.
REQ-017 imem_addr SHALL equal PC[AW+1:2] combinationally in every state; addresses wrap modulo 2^AW.
REQ-018 Pop SHALL occur when instr_valid && instr_ready.
REQ-019 Push SHALL occur in RUN when no redirect is active and (count < DEPTH or pop), writing {imem_q, PC} and advancing PC by 4 (64-bit wrap).
REQ-020 Simultaneous push and pop SHALL leave count unchanged; FIFO order SHALL be strictly preserved.
REQ-021 Fetch latency: a word pushed at edge N SHALL appear on instr_* after edge N when the queue was empty; no combinational path from imem_q to instr_*.
REQ-022 instr_valid SHALL equal (count != 0); when 0, instr_data SHALL be NOP_WORD and instr_pc 0.
REQ-023 Redirect SHALL take priority over push and pop in its cycle: the queue is flushed (count 0), PC loads {redirect_addr[63:2], 2'b00}, and no push occurs.
REQ-024 Redirect in HALT SHALL also move the FSM to RUN; redirect in RUN leaves it in RUN.
REQ-025 When a pushed word equals HALT_WORD, the FSM SHALL enter HALT at that edge; PC still advances by 4; the HALT_WORD entry is delivered normally.
REQ-026 In HALT no push SHALL occur; pops continue until the queue drains; halted = 1.
REQ-027 instr_ready while instr_valid = 0 SHALL have no effect.
REQ-028 redirect_addr low two bits SHALL be ignored; no error is raised.

Reset
REQ-029 While reset = 0 (asynchronous assertion, synchronous-safe release): PC = 0, count = 0, FSM = RUN, instr_valid = 0, instr_data = NOP_WORD, instr_pc = 0, halted = 0, imem_addr = 0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect immediately.
REQ-031 The first push after release SHALL occur at the first rising edge with reset = 1, fetching word 0.

Verification
REQ-032 Release reset, instr_ready = 1, ROM[0..3] distinct -> instr_valid from cycle 1, instr_pc 0, 4, 8, 12 on consecutive cycles, data ROM[0..3].
REQ-033 instr_ready = 0 for 6 cycles -> count saturates at 2, imem_addr holds at 2, then ready = 1 delivers pc 0, 4, 8 with no loss or duplication.
REQ-034 Queue full, redirect_valid = 1, redirect_addr = 0x2B -> next cycle instr_valid = 0; following cycle instr_pc = 0x28, instr_data = ROM[10].
REQ-035 HALT_WORD at ROM[20], ready = 1 -> halted = 1 after the edge that pushed pc 0x50; last delivered instr_pc = 0x50; imem_addr holds at 21.
REQ-036 In HALT, redirect to 0x0 -> halted = 0 next cycle, fetch resumes at pc 0.
REQ-037 Assert reset with 2 entries queued -> instr_valid = 0, instr_data = 0x8b1f03ff immediately (before the next clock edge); after release, fetch restarts at pc 0.
